ifetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the 16-bit × 256 program `true_dpram_sclk` (read port A) and feeds the decoder. It owns the fetch PC, issues one read per cycle into the RAM (1-cycle registered read latency), buffers returned words in a small circular queue, and presents them to decode over a valid/ready handshake. It also supports branch redirect (flush plus new PC) and halt.

---
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner and instruction buffer between the program RAM
// read port (1-cycle registered read) and the decoder. A read is only issued
// when the queue has room for it, counting the read still in flight, so
// returned words never need to be dropped for lack of space.
module ifetch_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ram_ena,
  output logic [7:0]  ram_addr,
  input  logic [15:0] ram_q,
  input  logic        halt,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        ins_valid,
  output logic [15:0] ins_data,
  output logic [7:0]  ins_pc,
  input  logic        ins_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    fetch_pc_reg, fetch_pc_next;
  logic          inflight_reg, inflight_next;
  logic [7:0]    inflight_pc_reg, inflight_pc_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  // Queue storage: one {data, pc} pair per entry.
  logic [15:0] data_mem [DEPTH];
  logic [7:0]  pc_mem   [DEPTH];

  logic          issue;
  logic          capture;
  logic          pop;
  logic [CW-1:0] credit;

  // Entries already held plus the word still coming back from the RAM.
  assign credit    = count_reg + CW'(inflight_reg);
  assign issue     = rst_n & ~redirect & ~halt & (credit < DEPTH_C);
  // A response landing in a redirect cycle belongs to the abandoned path.
  assign capture   = inflight_reg & ~redirect;
  assign ins_valid = rst_n & (count_reg != '0);
  assign pop       = ins_valid & ins_ready;

  assign ram_ena   = issue;
  assign ram_addr  = fetch_pc_reg;

  // Head entry straight out of the storage flops; no path from redirect/ready.
  assign ins_data  = data_mem[head_reg];
  assign ins_pc    = pc_mem[head_reg];

  // Next-state: issue/capture/pop bookkeeping, redirect overrides everything.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_next    = issue;
    inflight_pc_next = inflight_pc_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;
    count_next       = count_reg + CW'(capture) - CW'(pop);

    if (issue) begin
      inflight_pc_next = fetch_pc_reg;
      fetch_pc_next    = fetch_pc_reg + 8'd1;
    end
    if (capture) begin
      tail_next = tail_reg + PW'(1);
    end
    if (pop) begin
      head_next = head_reg + PW'(1);
    end

    if (redirect) begin
      fetch_pc_next = redirect_pc;
      inflight_next = 1'b0;
      head_next     = '0;
      tail_next     = '0;
      count_next    = '0;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 8'h00;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      count_reg       <= count_next;
    end
  end

  // Write the returning word and its address into the tail entry.
  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      data_mem[tail_reg] <= ram_q;
      pc_mem[tail_reg]   <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios followed by randomized control traffic.
// A credit-based reference model predicts ram_ena/ram_addr/ins_valid every
// cycle, and a scoreboard of expected {pc, data} pairs is checked on every
// decoder handshake.
module tb_ifetch_queue;

  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h10;

  logic        clk;
  logic        rst_n;
  logic        ram_ena;
  logic [7:0]  ram_addr;
  logic [15:0] ram_q;
  logic        halt;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        ins_valid;
  logic [15:0] ins_data;
  logic [7:0]  ins_pc;
  logic        ins_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem [256];

  // Reference model state: totals since the last reset/redirect.
  int          m_issued   = 0;
  int          m_pops     = 0;
  bit          m_inflight = 1'b0;
  logic [7:0]  m_issue_pc = RESET_PC;
  logic [23:0] sb[$];

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ram_ena     (ram_ena),
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    ram_q = 16'h0000;
  end

  // Program RAM stand-in: registered read, one cycle latency.
  always @(posedge clk) begin
    if (ram_ena) ram_q <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // New fetch stream: expected deliveries are consecutive pcs from start.
  task automatic start_segment(input logic [7:0] start);
    logic [7:0] p;
    sb.delete();
    p = start;
    for (int i = 0; i < 256; i++) begin
      sb.push_back({p, mem[p]});
      p = p + 8'd1;
    end
    m_issued   = 0;
    m_pops     = 0;
    m_inflight = 1'b0;
    m_issue_pc = start;
  endtask

  // Monitor: compare this cycle's outputs to the model, then advance it.
  always @(negedge clk) begin
    int          cnt;
    bit          exp_valid;
    bit          exp_ena;
    logic [23:0] exp_item;
    cnt       = m_issued - m_pops - (m_inflight ? 1 : 0);
    exp_valid = rst_n && (cnt > 0);
    exp_ena   = rst_n && !redirect && !halt && ((cnt + (m_inflight ? 1 : 0)) < DEPTH);
    check("ins_valid", 32'(ins_valid), 32'(exp_valid));
    check("ram_ena", 32'(ram_ena), 32'(exp_ena));
    if (exp_ena) check("ram_addr", 32'(ram_addr), 32'(m_issue_pc));
    if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: got pc %02h, expected no transfer", ins_pc);
      end else begin
        exp_item = sb.pop_front();
        check("ins_pc", 32'(ins_pc), 32'(exp_item[23:16]));
        check("ins_data", 32'(ins_data), 32'(exp_item[15:0]));
        $display("xfer pc=%02h data=%04h", ins_pc, ins_data);
      end
    end
    if (!rst_n) begin
      start_segment(RESET_PC);
    end else if (redirect) begin
      start_segment(redirect_pc);
    end else begin
      if (exp_valid && ins_ready) m_pops++;
      if (exp_ena) begin
        m_issued++;
        m_issue_pc = m_issue_pc + 8'd1;
      end
      m_inflight = exp_ena;
    end
  end

  // Observe the current cycle at the falling edge, then move to the next one.
  task automatic cycle(output bit v, output bit e, output bit hs, output logic [7:0] pc);
    @(negedge clk);
    v  = ins_valid;
    e  = ram_ena;
    hs = ins_valid && ins_ready;
    pc = ins_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit v, e, hs;
    logic [7:0] pc;
    repeat (n) cycle(v, e, hs, pc);
  endtask

  // Redirect in cycle R, then verify the R+1..R+3 timing.
  task automatic do_redirect(input logic [7:0] target);
    bit v, e, hs;
    logic [7:0] pc;
    redirect    = 1'b1;
    redirect_pc = target;
    cycle(v, e, hs, pc);
    check("redir_no_issue_r", 32'(e), 32'd0);
    redirect    = 1'b0;
    redirect_pc = 8'($urandom);
    ins_ready   = 1'b1;
    cycle(v, e, hs, pc);
    check("redir_valid_r1", 32'(v), 32'd0);
    check("redir_issue_r1", 32'(e), 32'd1);
    cycle(v, e, hs, pc);
    check("redir_valid_r2", 32'(v), 32'd0);
    cycle(v, e, hs, pc);
    check("redir_valid_r3", 32'(v), 32'd1);
    check("redir_pc_r3", 32'(pc), 32'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, e, hs;
    logic [7:0] pc;
    int ti, tv, ne, nh, seg;

    rst_n       = 1'b0;
    ins_ready   = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;

    // Reset state and first-fetch latency.
    repeat (3) begin
      cycle(v, e, hs, pc);
      check("reset_valid", 32'(v), 32'd0);
      check("reset_ena", 32'(e), 32'd0);
    end
    rst_n = 1'b1;
    ti = -1;
    tv = -1;
    for (int k = 0; k < 10; k++) begin
      cycle(v, e, hs, pc);
      if (e && ti < 0) ti = k;
      if (v && tv < 0) tv = k;
    end
    check("first_issue_cycle", 32'(ti), 32'd0);
    check("first_valid_latency", 32'(tv - ti), 32'd2);
    run(6);

    // PC wrap through FF -> 00.
    do_redirect(8'hFE);
    run(8);

    // Backpressure from reset: exactly DEPTH reads, then drain without gaps.
    rst_n     = 1'b0;
    ins_ready = 1'b0;
    run(1);
    rst_n = 1'b1;
    ne = 0;
    repeat (10) begin
      cycle(v, e, hs, pc);
      if (e) ne++;
    end
    check("bp_issue_count", 32'(ne), 32'(DEPTH));
    ins_ready = 1'b1;
    nh = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(v, e, hs, pc);
      if (hs) nh++;
      if (k == 0) check("bp_head_pc", 32'(pc), 32'h10);
    end
    check("bp_drain_handshakes", 32'(nh), 32'd5);

    // Redirect with three entries queued and one read in flight.
    rst_n     = 1'b0;
    ins_ready = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(4);
    do_redirect(8'h40);
    run(6);

    // Halt mid-stream: in-flight word delivered, no issue while halted.
    halt = 1'b1;
    ne = 0;
    nh = 0;
    repeat (5) begin
      cycle(v, e, hs, pc);
      if (e) ne++;
      if (hs) nh++;
    end
    halt = 1'b0;
    check("halt_issue_count", 32'(ne), 32'd0);
    check("halt_drained", 32'(nh), 32'd2);
    run(8);

    // Reset mid-stream with a read in flight.
    rst_n = 1'b0;
    cycle(v, e, hs, pc);
    check("midrst_valid", 32'(v), 32'd0);
    check("midrst_ena", 32'(e), 32'd0);
    rst_n = 1'b1;
    cycle(v, e, hs, pc);
    check("post_rst_valid", 32'(v), 32'd0);
    run(6);

    // Randomized control traffic; each fetch stream is kept short.
    seg = 0;
    for (int n = 0; n < 3000; n++) begin
      ins_ready   = ($urandom_range(0, 9) < 7);
      halt        = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 29) == 0) || (seg >= 120);
      redirect_pc = 8'($urandom);
      rst_n       = !($urandom_range(0, 199) == 0);
      if (redirect || !rst_n) seg = 0;
      else seg++;
      cycle(v, e, hs, pc);
    end
    rst_n    = 1'b1;
    halt     = 1'b0;
    redirect = 1'b0;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
